led_pattern_controller: RTL and testbench
=========================================

# led_pattern_controller

Sequencer for the 10-LED bar: owns the step prescaler and selects and advances one of four display patterns (off, bouncing scan, fill, blink) under control of mode-load, speed and pause requests from the board switch and button logic. Sits between the debounced user inputs and the LED output pins. It replaces free-running per-pattern drivers with one registered, restartable pattern engine.

## Interface

- `WIDTH`, default 10, number of LEDs (≥2).
- `TICK_DIV`, default 500000, base step period in clk cycles (≥2).
- `clk` input 1: system clock, all state on posedge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `mode_req` input 2: requested mode, 0=OFF, 1=SCAN, 2=FILL, 3=BLINK; sampled only with `mode_load`.
- `mode_load` input 1: single-cycle pulse; latch `mode_req` and restart the pattern.
- `speed_up` input 1: single-cycle pulse; speed level +1, saturating at 3.
- `speed_dn` input 1: single-cycle pulse; speed level −1, saturating at 0.
- `pause` input 1: level; freeze prescaler and pattern while high.
- `out` output WIDTH: registered LED drive, bit 0 = leftmost LED.
- `step` output 1: registered one-cycle pulse, coincident with each pattern advance.
- `mode` output 2: currently active mode.

## Operation

- Reset values: `mode`=1 (SCAN), speed level `spd`=2, prescaler `cnt`=0, scan position `pos`=0, direction=up, `out`=1 (bit 0 only), `step`=0.
- Step period `P` = TICK_DIV << (3 − spd). spd 3 is fastest (TICK_DIV). spd 0 is slowest (8·TICK_DIV).
- Prescaler: when `pause`=0 and `cnt` ≥ P−1, then `cnt`←0 and a step occurs. Otherwise, with `pause`=0, `cnt`←cnt+1. With `pause`=1, `cnt`, `out` and direction hold, and `step`=0.
- The ≥ compare is required. If a speed increase makes P−1 less than the current `cnt`, the step fires on the next cycle. There is no runaway wrap.
- Speed: `speed_up` and `speed_dn` high together cause no change. Saturation is silent. Speed changes do not reset `cnt` and do not restart the pattern.
- Mode load takes precedence over a step in the same cycle. At that edge:
  - `mode`←mode_req, `cnt`←0, `step`←0.
  - Pattern restarts to its initial value: OFF 0; SCAN pos 0, dir up, out=1; FILL out=0; BLINK out all ones.
  - Applies even while `pause`=1. The pattern then stays frozen at the restart value.
  - Reloading the current mode still restarts it.
- Pattern advance on each step:
  - **OFF**: `out` stays 0. `step` still pulses.
  - **SCAN**: at pos=WIDTH−1 dir←down; at pos=0 dir←up; pos←pos±1 using the updated dir. `out` is one-hot at pos, so exactly one bit is always set. Sequence for WIDTH=10: 0,1,…,9,8,…,1,0,1,… Endpoints are shown once per bounce, with no double-dwell.
  - **FILL**: if `out` is all ones, out←0; otherwise out←(out<<1)|1. Sequence: 0,1,3,7,…,2^WIDTH−1,0,1,…
  - **BLINK**: out←~out. Out stays all zeros or all ones.
- `out` is never driven to X or Z. Invalid intermediate states are not permitted.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- Step latency: `out` and `step` change on the same edge where `cnt` = P−1 is sampled. `step` is high for exactly one cycle. The next step is P cycles later.
- From `mode_load` sampled high, the new `mode` and restart `out` are visible after that edge (1-cycle latency). The first step follows P cycles later.
- From `pause` falling, counting resumes from the held `cnt`. Total elapsed unpaused cycles per step stay equal to P.
- `reset` asserted mid-operation sets every output to its reset value asynchronously. The first posedge after deassertion counts `cnt` 0→1.

## Test plan

- Reset and SCAN bounce, TICK_DIV=4, spd=2 (P=8): `out` starts at 0x001, with `step` every 8 cycles. `out` sequence is 0x001,0x002,…,0x200,0x100,…,0x001,0x002, and exactly one bit is set at every cycle.
- FILL then BLINK: load mode 2 → `out`=0, then 0x001,0x003,…,0x3FF,0x000 on successive steps. Load mode 3 → 0x3FF,0x000,0x3FF.
- Speed: three `speed_up` pulses → spd saturates at 3 and P=4. Four `speed_dn` pulses → spd=0 and P=32. Simultaneous up and down → no change. Drop spd 0→3 while `cnt`=20 → step on the next cycle.
- Pause: hold `pause` 50 cycles mid-SCAN → `out`, `cnt` and `step` are frozen. After release, the step arrives after the remaining P−cnt cycles.
- Collision: `mode_load` (mode 1) on the same cycle as a due step → no `step` pulse, `out`=0x001, next step P cycles later.
- Async reset mid-FILL at `out`=0x07F → `out`=0x001, `mode`=1 and `step`=0 before the next clk edge.

Source files
------------

// File: rtl/led_pattern_controller.sv
// Restartable LED bar pattern engine (OFF/SCAN/FILL/BLINK) with a speed-scaled step prescaler.
// Outputs are registered with 1-cycle latency, and pause freezes the prescaler and the pattern.
module led_pattern_controller #(
  parameter int WIDTH    = 10,
  parameter int TICK_DIV = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode_req,
  input  logic             mode_load,
  input  logic             speed_up,
  input  logic             speed_dn,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {M_OFF = 2'd0, M_SCAN = 2'd1, M_FILL = 2'd2, M_BLINK = 2'd3} mode_t;

  localparam int CW = $clog2(8 * TICK_DIV) + 1;
  localparam int PW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  mode_t            r_mode, w_mode_nxt;
  logic [1:0]       r_spd, w_spd_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_period;
  logic [PW-1:0]    r_pos, w_pos_nxt, w_pos_adv;
  logic             r_dir, w_dir_nxt, w_dir_adv;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_step, w_step_nxt;
  logic             w_due;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= M_SCAN;
      r_spd  <= 2'd2;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_dir  <= 1'b1;
      r_out  <= WIDTH'(1);
      r_step <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_spd  <= w_spd_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pos  <= w_pos_nxt;
      r_dir  <= w_dir_nxt;
      r_out  <= w_out_nxt;
      r_step <= w_step_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_spd_nxt  = r_spd;
    w_cnt_nxt  = r_cnt;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_out_nxt  = r_out;
    w_step_nxt = 1'b0;

    w_period = CW'(TICK_DIV) << (2'd3 - r_spd);
    // >= rather than == so a speed-up that shrinks P below cnt fires at once
    w_due    = (r_cnt >= (w_period - CW'(1)));

    // Bounce turns around at the ends before moving, so endpoints dwell one step only
    w_dir_adv = r_dir;
    if (r_pos == PW'(WIDTH - 1)) w_dir_adv = 1'b0;
    else if (r_pos == '0)        w_dir_adv = 1'b1;
    w_pos_adv = w_dir_adv ? (r_pos + PW'(1)) : (r_pos - PW'(1));

    if (speed_up && !speed_dn && r_spd != 2'd3) w_spd_nxt = r_spd + 2'd1;
    if (speed_dn && !speed_up && r_spd != 2'd0) w_spd_nxt = r_spd - 2'd1;

    if (mode_load) begin
      w_mode_nxt = mode_t'(mode_req);
      w_cnt_nxt  = '0;
      w_pos_nxt  = '0;
      w_dir_nxt  = 1'b1;
      case (mode_t'(mode_req))
        M_SCAN:  w_out_nxt = WIDTH'(1);
        M_BLINK: w_out_nxt = ALL_ONES;
        default: w_out_nxt = '0;
      endcase
    end else if (!pause) begin
      if (w_due) begin
        w_cnt_nxt  = '0;
        w_step_nxt = 1'b1;
        case (r_mode)
          M_SCAN: begin
            w_dir_nxt = w_dir_adv;
            w_pos_nxt = w_pos_adv;
            w_out_nxt = WIDTH'(1) << w_pos_adv;
          end
          M_FILL:  w_out_nxt = (r_out == ALL_ONES) ? '0 : ((r_out << 1) | WIDTH'(1));
          M_BLINK: w_out_nxt = ~r_out;
          default: w_out_nxt = '0;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  assign out  = r_out;
  assign step = r_step;
  assign mode = r_mode;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller with WIDTH=10, TICK_DIV=4 (P=8 at reset speed).
// Expected values are hand-derived step counts and LED patterns.
module tb_led_pattern_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_load = 1'b0;
  logic       speed_up = 1'b0;
  logic       speed_dn = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] out;
  logic       step;
  logic [1:0] mode;

  int n_vec = 0;
  int n_err = 0;

  led_pattern_controller #(.WIDTH(10), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_load(mode_load),
    .speed_up(speed_up), .speed_dn(speed_dn), .pause(pause),
    .out(out), .step(step), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      chk("quiet_step", step, 0);
    end
  endtask

  task automatic load(input logic [1:0] m);
    mode_req  = m;
    mode_load = 1'b1;
    tick(1);
    mode_load = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_out;
    int p;

    tick(2);
    chk("rst_out", out, 10'h001);
    chk("rst_mode", mode, 1);
    chk("rst_step", step, 0);
    reset = 1'b0;

    // SCAN bounce: positions 1..9, 8..0, 1, 2
    for (int s = 1; s <= 20; s++) begin
      p = s % 18;
      if (p > 9) p = 18 - p;
      exp_out = 10'h001 << p;
      for (int c = 1; c <= 8; c++) begin
        tick(1);
        chk("scan_onehot", $countones(out), 1);
        if (c < 8) chk("scan_nostep", step, 0);
        else begin
          chk("scan_step", step, 1);
          chk("scan_out", out, exp_out);
        end
      end
    end

    // Pause with cnt=3, pos=2
    tick(3);
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i % 10 == 9) begin
        chk("pause_out", out, 10'h004);
        chk("pause_step", step, 0);
      end
    end
    pause = 1'b0;
    run_quiet(4);
    tick(1);
    chk("resume_step", step, 1);
    chk("resume_out", out, 10'h008);

    // Mode load collides with a due step
    tick(7);
    load(2'd1);
    chk("coll_step", step, 0);
    chk("coll_out", out, 10'h001);
    chk("coll_mode", mode, 1);
    run_quiet(7);
    tick(1);
    chk("coll_next_step", step, 1);
    chk("coll_next_out", out, 10'h002);

    // FILL
    load(2'd2);
    chk("fill_mode", mode, 2);
    chk("fill_init", out, 10'h000);
    for (int s = 1; s <= 11; s++) begin
      exp_out = (s <= 10) ? 10'((1 << s) - 1) : 10'h000;
      run_quiet(7);
      tick(1);
      chk("fill_step", step, 1);
      chk("fill_out", out, exp_out);
    end

    // BLINK
    load(2'd3);
    chk("blink_mode", mode, 3);
    chk("blink_init", out, 10'h3FF);
    run_quiet(7);
    tick(1);
    chk("blink_out1", out, 10'h000);
    run_quiet(7);
    tick(1);
    chk("blink_out2", out, 10'h3FF);

    // Asynchronous reset mid-FILL at 0x07F
    load(2'd2);
    for (int s = 1; s <= 7; s++) tick(8);
    chk("prerst_out", out, 10'h07F);
    #3 reset = 1'b1;
    #1;
    chk("arst_out", out, 10'h001);
    chk("arst_mode", mode, 1);
    chk("arst_step", step, 0);
    #2 reset = 1'b0;
    run_quiet(7);
    chk("postrst_out", out, 10'h001);
    tick(1);
    chk("postrst_step", step, 1);
    chk("postrst_out2", out, 10'h002);

    // Speed saturates at 3: P=4
    speed_up = 1'b1;
    tick(3);
    speed_up = 1'b0;
    load(2'd3);
    chk("spd3_init", out, 10'h3FF);
    run_quiet(3);
    tick(1);
    chk("spd3_step", step, 1);
    chk("spd3_out", out, 10'h000);

    // Speed saturates at 0: P=32
    speed_dn = 1'b1;
    tick(4);
    speed_dn = 1'b0;
    load(2'd3);
    run_quiet(31);
    tick(1);
    chk("spd0_step", step, 1);

    // Simultaneous up and down leaves P=32
    load(2'd3);
    speed_up = 1'b1;
    speed_dn = 1'b1;
    tick(1);
    speed_up = 1'b0;
    speed_dn = 1'b0;
    chk("both_nostep", step, 0);
    run_quiet(30);
    tick(1);
    chk("both_step", step, 1);

    // Speed-up past cnt=20 fires on the next cycle
    run_quiet(20);
    speed_up = 1'b1;
    tick(1);
    chk("fast_nostep", step, 0);
    tick(1);
    chk("fast_step", step, 1);
    tick(1);
    speed_up = 1'b0;
    chk("fast_after", step, 0);
    run_quiet(2);
    tick(1);
    chk("fast_p4_step", step, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
